// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth_table_sweeper block.
//   tt_state_e  : sweeper FSM state encoding
//   DEF_N_IN    : default function input count
//   NVEC        : number of input vectors for the default input count
//   mask_width  : minterm-mask width for an n-input function (2^n)
package tt_pkg;

  localparam int unsigned DEF_N_IN = 4;
  localparam int unsigned NVEC     = 1 << DEF_N_IN;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StSample,
    StDone
  } tt_state_e;

  function automatic int unsigned mask_width(int unsigned n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bundle between the sweeper and whatever drives/observes it.
//   master : controller side (drives start/expected, returns the function output s_in)
//   slave  : sweeper side (drives vec_out, status and result fields)
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN = 4
);
  localparam int unsigned NvecL = tt_pkg::mask_width(N_IN);

  logic              start;
  logic [NvecL-1:0]  expected;
  logic              s_in;
  logic [N_IN-1:0]   vec_out;
  logic              busy;
  logic              done;
  logic [NvecL-1:0]  minterms;
  logic [N_IN:0]     err_count;
  logic [N_IN-1:0]   first_err;
  logic              first_err_vld;
  logic              pass;

  modport master (
    output start, expected, s_in,
    input  vec_out, busy, done, minterms, err_count, first_err, first_err_vld, pass
  );

  modport slave (
    input  start, expected, s_in,
    output vec_out, busy, done, minterms, err_count, first_err, first_err_vld, pass
  );
endinterface

// File: rtl/tt_settle_cnt.sv
// Settle-time counter: counts enabled cycles 0..SETTLE-1 and pulses tc_o on the last one,
// then wraps to zero.
//   clk_i : clock          rst_i : synchronous active-high reset
//   clr_i : clear to zero  en_i  : count enable      tc_o : terminal-count pulse
module tt_settle_cnt #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == CntW'(SETTLE - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (tc_o) cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked driver/monitor that sweeps every input vector of an N_IN-input Boolean function,
// records the observed minterm mask and compares it against an expected mask.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, aborts any sweep
//   bus   : slave side of truth_table_sweeper_if (start/expected/s_in in, results out)
// Optional build macro TT_STOP_ON_ERR_EN: end the sweep at the first mismatching vector.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  truth_table_sweeper_if.slave  bus
);
  localparam int unsigned NV   = mask_width(N_IN);
  localparam int unsigned ErrW = N_IN + 1;

  tt_state_e         state_q, state_d;
  logic [NV-1:0]     exp_q, exp_d;
  logic [NV-1:0]     mint_q, mint_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [ErrW-1:0]   err_q, err_d;
  logic [N_IN-1:0]   fe_q, fe_d;
  logic              fev_q, fev_d;
  logic              done_q, done_d;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic              mismatch, stop;

  tt_settle_cnt #(.SETTLE(SETTLE)) u_settle_cnt (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  assign mismatch = (bus.s_in != exp_q[vec_q]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      exp_q   <= '0;
      mint_q  <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      fe_q    <= '0;
      fev_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      mint_q  <= mint_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fe_q    <= fe_d;
      fev_q   <= fev_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    mint_d  = mint_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fe_d    = fe_q;
    fev_d   = fev_q;
    done_d  = done_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
`ifdef TT_STOP_ON_ERR_EN
    stop    = mismatch;
`else
    stop    = 1'b0;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          exp_d   = bus.expected;
          mint_d  = '0;
          err_d   = '0;
          fe_d    = '0;
          fev_d   = 1'b0;
          done_d  = 1'b0;
          vec_d   = '0;
          cnt_clr = 1'b1;
          state_d = StApply;
        end
      end
      StApply: begin
        cnt_en = 1'b1;
        if (cnt_tc) state_d = StSample;
      end
      StSample: begin
        mint_d[vec_q] = bus.s_in;
        if (mismatch) begin
          err_d = err_q + ErrW'(1);
          if (!fev_q) begin
            fe_d  = vec_q;
            fev_d = 1'b1;
          end
        end
        // The last vector holds on vec_out; no wrap inside a sweep.
        if (vec_q == N_IN'(NV - 1) || stop) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          vec_d   = vec_q + N_IN'(1);
          cnt_clr = 1'b1;
          state_d = StApply;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy          = (state_q == StApply) || (state_q == StSample);
    bus.done          = done_q;
    bus.pass          = done_q && (err_q == '0);
    bus.vec_out       = vec_q;
    bus.minterms      = mint_q;
    bus.err_count     = err_q;
    bus.first_err     = fe_q;
    bus.first_err_vld = fev_q;
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: each accepted start pushes the hand-computed
// result; a monitor pops and compares on every rising edge of done.
module tb_truth_table_sweeper;

  typedef struct {
    logic [15:0] mint;
    logic [4:0]  err;
    logic [3:0]  fe;
    logic        fev;
    logic        pass;
    logic [3:0]  vec;
    longint      t_acc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] model_mask;
  exp_t        sb_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic        done_prev = 1'b0;

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(4)) bus ();

  assign bus.s_in = model_mask[bus.vec_out];

  truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(logic [15:0] mint, logic [4:0] err, logic [3:0] fe, logic fev,
                              logic pass, logic [3:0] vec, int lat);
    exp_t x;
    x.mint = mint; x.err = err; x.fe = fe; x.fev = fev;
    x.pass = pass; x.vec = vec; x.lat = lat; x.t_acc = 0;
    return x;
  endfunction

  // Monitor: one scoreboard entry per completed sweep.
  always @(negedge clk) begin
    if (bus.done && !done_prev) begin
      check("sb_has_entry", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("minterms", 64'(bus.minterms), 64'(e.mint));
        check("err_count", 64'(bus.err_count), 64'(e.err));
        check("first_err_vld", 64'(bus.first_err_vld), 64'(e.fev));
        if (e.fev) check("first_err", 64'(bus.first_err), 64'(e.fe));
        check("pass", 64'(bus.pass), 64'(e.pass));
        check("vec_out", 64'(bus.vec_out), 64'(e.vec));
        check("busy_in_done", 64'(bus.busy), 64'd0);
        check("latency", 64'(($time - 5 - e.t_acc) / 10), 64'(e.lat));
      end
    end
    done_prev = bus.done;
  end

  task automatic issue(logic [15:0] e, logic [15:0] m, exp_t x);
    @(negedge clk);
    bus.expected = e;
    model_mask   = m;
    bus.start    = 1'b1;
    x.t_acc      = $time + 5;
    sb_q.push_back(x);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!bus.done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", 64'(bus.done), 64'd1);
  endtask

  task automatic wait_vec(logic [3:0] v);
    int k = 0;
    while (!(bus.busy && bus.vec_out == v) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("vec_reached", 64'(bus.vec_out), 64'(v));
  endtask

  task automatic check_zero(string tag);
    check({tag, "_vec"}, 64'(bus.vec_out), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_mint"}, 64'(bus.minterms), 64'd0);
    check({tag, "_err"}, 64'(bus.err_count), 64'd0);
    check({tag, "_fe"}, 64'(bus.first_err), 64'd0);
    check({tag, "_fev"}, 64'(bus.first_err_vld), 64'd0);
    check({tag, "_pass"}, 64'(bus.pass), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.expected = '0;
    model_mask   = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // 1: exact match.
    issue(16'h230D, 16'h230D, mk(16'h230D, 5'd0, 4'd0, 1'b0, 1'b1, 4'd15, 32));
    wait_done();

    // 2: single mismatch on vector 0.
`ifdef TT_STOP_ON_ERR_EN
    issue(16'h230C, 16'h230D, mk(16'h0001, 5'd1, 4'd0, 1'b1, 1'b0, 4'd0, 2));
`else
    issue(16'h230C, 16'h230D, mk(16'h230D, 5'd1, 4'd0, 1'b1, 1'b0, 4'd15, 32));
`endif
    wait_done();

    // 3: reset mid-sweep, then a clean sweep.
    issue(16'h230D, 16'h230D, mk(16'h230D, 5'd0, 4'd0, 1'b0, 1'b1, 4'd15, 32));
    wait_vec(4'd5);
    reset = 1'b1;
    @(negedge clk);
    check_zero("abort");
    reset = 1'b0;
    sb_q.delete();
    issue(16'h230D, 16'h230D, mk(16'h230D, 5'd0, 4'd0, 1'b0, 1'b1, 4'd15, 32));
    wait_done();

    // 4: start while busy, with a different expected mask, is ignored.
    issue(16'h230D, 16'h230D, mk(16'h230D, 5'd0, 4'd0, 1'b0, 1'b1, 4'd15, 32));
    wait_vec(4'd3);
    bus.expected = 16'hFFFF;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // 5: mismatch on vector 2.
`ifdef TT_STOP_ON_ERR_EN
    issue(16'h230D, 16'h2309, mk(16'h0001, 5'd1, 4'd2, 1'b1, 1'b0, 4'd2, 6));
`else
    issue(16'h230D, 16'h2309, mk(16'h2309, 5'd1, 4'd2, 1'b1, 1'b0, 4'd15, 32));
`endif
    wait_done();

    // 6: restart from DONE clears results.
    issue(16'h0000, 16'h0000, mk(16'h0000, 5'd0, 4'd0, 1'b0, 1'b1, 4'd15, 32));
    check("restart_done_clr", 64'(bus.done), 64'd0);
    check("restart_mint_clr", 64'(bus.minterms), 64'd0);
    check("restart_err_clr", 64'(bus.err_count), 64'd0);
    check("restart_fev_clr", 64'(bus.first_err_vld), 64'd0);
    check("restart_busy", 64'(bus.busy), 64'd1);
    wait_done();

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Hardware self-checking sweeper for an N-input combinational Boolean function.
- Drives every input vector 0..2^N-1 in ascending order, waits a settle time, then samples the function output.
- Assembles the observed minterm mask and compares it bit-by-bit against an expected minterm mask.
- Sits around the combinational expression modules as the clocked driver/monitor for on-chip (FPGA) verification.

Parameters:
- N_IN, 4, number of function inputs. vec_out[N_IN-1] maps to x, then y, w, z down to bit 0.
- SETTLE, 1, cycles each vector is held before sampling. Legal range is >=1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse that begins a sweep. Accepted only in IDLE or DONE.
- expected  in  2^N_IN  expected minterm mask. Bit i = f(i). Sampled once when start is accepted.
- s_in  in  1  output of the function under test.
- vec_out  out  N_IN  current input vector applied to the function.
- busy  out  1  high during APPLY/SAMPLE.
- done  out  1  high in DONE. Sticky until the next accepted start or reset.
- minterms  out  2^N_IN  observed mask. Bit i is set when s_in=1 while vec_out=i.
- err_count  out  N_IN+1  number of mismatching vectors.
- first_err  out  N_IN  lowest mismatching vector.
- first_err_vld  out  1  first_err is meaningful.
- pass  out  1  done & (err_count==0).

Behaviour:
- Reset: all outputs 0. State goes to IDLE. exp_q is cleared. Reset takes priority over everything, including mid-sweep; it aborts with no residue.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE/DONE with start=1:
  - exp_q <= expected.
  - Clear minterms, err_count, first_err, first_err_vld, done.
  - vec_out <= 0, settle counter <= 0.
  - Go to APPLY.
- APPLY: the counter increments each cycle. When counter==SETTLE-1, go to SAMPLE.
- SAMPLE, at the closing edge:
  - minterms[vec_out] <= s_in.
  - If s_in != exp_q[vec_out]: err_count+1. If !first_err_vld, set first_err <= vec_out and first_err_vld <= 1.
  - Then:
    - If vec_out == 2^N_IN-1: go to DONE, done <= 1. vec_out holds its last value.
    - Otherwise: vec_out+1, counter cleared, go to APPLY.
- Latency: done rises exactly 2^N_IN*(SETTLE+1) cycles after the start-accept edge. Defaults give 32.
- start while busy is ignored. A change of expected after acceptance has no effect.
- start in DONE restarts the sweep with the same clearing behaviour as from IDLE.
- vec_out never wraps inside a sweep.
- err_count cannot overflow, since its maximum is 2^N_IN.
- pass is combinational from done and err_count.

Optional Feature:
- TT_STOP_ON_ERR_EN defined: on the first mismatch in SAMPLE, go directly to DONE.
  - done=1, err_count=1, first_err=that vector.
  - vec_out holds the failing vector.
  - minterms holds bits only up to and including that vector; higher bits are 0.
- TT_STOP_ON_ERR_EN undefined: the full sweep always completes.

Decomposition:
- Package tt_pkg:
  - state enum {IDLE, APPLY, SAMPLE, DONE}.
  - localparam NVEC = 1<<N_IN.
  - function mask_width(n).
- One sub-module, tt_settle_cnt: a SETTLE-deep counter with clr, en and a terminal-count pulse.

Test Plan:
- Bench model for all scenarios: s_in = model_mask[vec_out] (combinational), with defaults.
- Scenario 1: expected=16'h230D (minterms 0,2,3,8,9,13), model 16'h230D, start -> done at cycle 32, minterms=16'h230D, err_count=0, pass=1, first_err_vld=0.
- Scenario 2: expected=16'h230C, model 16'h230D -> err_count=1, first_err=0, first_err_vld=1, pass=0, minterms=16'h230D.
- Scenario 3: reset asserted while vec_out=5 -> next cycle all outputs 0, state IDLE. A new start then completes a normal 32-cycle sweep.
- Scenario 4: start re-pulsed at vec_out=3 with expected changed to 16'hFFFF -> ignored. Results match scenario 1 timing and values.
- Scenario 5 (TT_STOP_ON_ERR_EN): expected=16'h230D, model 16'h2309 -> done after 6 cycles, vec_out=2, err_count=1, minterms=16'h0001.
- Scenario 6: start in DONE with expected=16'h0000, model 16'h0000 -> results cleared, then pass=1 after 32 cycles.
